// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream_demux router: buffering mode encoding
// and the select-width helper.
package stream_demux_pkg;

  // Buffering modes for each output lane
  localparam int PASSTHRU = 0;  // combinational, no state
  localparam int SKID     = 1;  // 2-entry skid buffer, registered ready
  localparam int OUTREG   = 2;  // 1-entry output register

  // Width of a lane index; at least one bit even for a single lane
  function automatic int sel_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_lane.sv
// One output lane of stream_demux: a valid/ready buffer that is either a
// 2-entry skid buffer (ready fully registered) or a single output register.
module stream_demux_lane
  import stream_demux_pkg::*;
#(
  parameter int DATAW    = 1,
  parameter int BUFFERED = SKID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  generate
    if (BUFFERED == SKID) begin : g_skid
      logic             r_main_valid;
      logic             r_shadow_valid;
      logic [DATAW-1:0] r_main_data;
      logic [DATAW-1:0] r_shadow_data;
      logic             w_accept;
      logic             w_to_main;

      // Ready depends only on the shadow flop, so ready_out never reaches
      // ready_in combinationally.
      assign ready_in  = !r_shadow_valid;
      assign w_accept  = valid_in && !r_shadow_valid;
      assign w_to_main = !r_main_valid || ready_out;

      // Occupancy flags: shadow refills main first, then accept, then drain
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_main_valid   <= 1'b0;
          r_shadow_valid <= 1'b0;
        end else if (ready_out && r_shadow_valid) begin
          r_shadow_valid <= 1'b0;
        end else if (w_accept) begin
          if (w_to_main) begin
            r_main_valid <= 1'b1;
          end else begin
            r_shadow_valid <= 1'b1;
          end
        end else if (ready_out) begin
          r_main_valid <= 1'b0;
        end
      end

      // Payload follows the same priority as the flags; not reset
      always_ff @(posedge clk) begin
        if (ready_out && r_shadow_valid) begin
          r_main_data <= r_shadow_data;
        end else if (w_accept) begin
          if (w_to_main) begin
            r_main_data <= data_in;
          end else begin
            r_shadow_data <= data_in;
          end
        end
      end

      assign valid_out = r_main_valid;
      assign data_out  = r_main_data;
    end else begin : g_outreg
      logic             r_valid;
      logic [DATAW-1:0] r_data;
      logic             w_accept;

      // A full register may drain and refill in the same cycle
      assign ready_in = !r_valid || ready_out;
      assign w_accept = valid_in && ready_in;

      // Valid flag: load on accept, clear when drained without refill
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_valid <= 1'b1;
        end else if (ready_out) begin
          r_valid <= 1'b0;
        end
      end

      // Payload capture on accept; not reset
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_data <= data_in;
        end
      end

      assign valid_out = r_valid;
      assign data_out  = r_data;
    end
  endgenerate

endmodule

// File: rtl/stream_demux.sv
// 1:N stream router. Steers one valid/ready input stream to one of NUM_REQS
// output lanes chosen per beat by sel_in; out-of-range selects are accepted
// and discarded with a one-cycle drop_out pulse.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  parameter  int DATAW    = 1,
  parameter  int BUFFERED = PASSTHRU,
  localparam int SEL_BITS = sel_bits(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [SEL_BITS-1:0]       sel_in,
  input  logic [DATAW-1:0]          data_in,
  output logic                      ready_in,
  output logic [NUM_REQS-1:0]       valid_out,
  output logic [NUM_REQS*DATAW-1:0] data_out,
  input  logic [NUM_REQS-1:0]       ready_out,
  output logic                      drop_out
);

  logic [NUM_REQS-1:0] w_lane_valid;
  logic [NUM_REQS-1:0] w_lane_ready;
  logic                w_sel_oob;
  logic                w_ready_sel;
  logic                r_drop;

  // A single lane ignores sel_in entirely, so nothing is ever out of range
  generate
    if (NUM_REQS == 1) begin : g_no_oob
      assign w_sel_oob = 1'b0;
    end else begin : g_oob
      assign w_sel_oob = (32'(sel_in) >= NUM_REQS);
    end
  endgenerate

  // Per-lane decode and buffering
  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
      // Masked by reset so pass-through lanes also show no valid in reset
      assign w_lane_valid[gi] = valid_in && !reset &&
                                ((NUM_REQS == 1) || (sel_in == SEL_BITS'(gi)));

      if (BUFFERED == PASSTHRU) begin : g_pass
        assign valid_out[gi]                = w_lane_valid[gi];
        assign data_out[gi*DATAW +: DATAW]  = data_in;
        assign w_lane_ready[gi]             = ready_out[gi];
      end else begin : g_buf
        stream_demux_lane #(
          .DATAW    (DATAW),
          .BUFFERED (BUFFERED)
        ) u_lane (
          .clk       (clk),
          .reset     (reset),
          .valid_in  (w_lane_valid[gi]),
          .data_in   (data_in),
          .ready_in  (w_lane_ready[gi]),
          .valid_out (valid_out[gi]),
          .data_out  (data_out[gi*DATAW +: DATAW]),
          .ready_out (ready_out[gi])
        );
      end
    end
  endgenerate

  // Ready of the addressed lane; out-of-range selects match no lane
  always_comb begin
    w_ready_sel = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if ((NUM_REQS == 1) || (sel_in == SEL_BITS'(i))) begin
        w_ready_sel = w_lane_ready[i];
      end
    end
  end

  assign ready_in = !reset && (w_sel_oob || w_ready_sel);

  // Drop pulse one cycle after a discarded beat (ready_in is 1 for those)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= valid_in && w_sel_oob;
    end
  end

  assign drop_out = r_drop;

endmodule
